spi_loader: RTL and testbench
=============================

Name: spi_loader

Overview:
- Target-side receiver for the serial program/data load link used by the FPGA demo.
- Deserializes 13-bit LSB-first frames from sclk/mosi, qualified by a 2-bit mode bus.
- Issues single-cycle write strobes into the core's instruction or data memory.
- Reports load completion and run/halt status on done_out.

Parameters:
- DATA_W, 8, payload width per frame.
- ADDR_W, 4, address width per frame; FRAME_LEN = ADDR_W+DATA_W+1 (13 by default).
- SYNC_STAGES, 2, flop stages on sclk_in, mosi_in and mode_in (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk_in  in  1  serial clock from the host driver; high and low phases each ≥2 clk.
- mosi_in  in  1  serial data, stable around the sclk rising edge.
- mode_in  in  2  00 idle, 01 instruction load, 10 data load, 11 run.
- halt_in  in  1  core has finished execution (level).
- wr_en  out  1  one-cycle write strobe.
- wr_sel  out  1  0 = instruction memory, 1 = data memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- done_out  out  1  load complete (load modes) or core halted (run mode).
- run_out  out  1  core enable; held while in run mode.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and synchronizers cleared.
- Synchronization:
  - sclk_in, mosi_in and mode_in all pass through SYNC_STAGES flops, so they share equal delay.
  - A rising edge is detected in the clk domain from synced sclk (current 1, previous 0).
  - Only synced signals are used internally.
- Frame format and shifting:
  - Bit i received is frame bit i, LSB first.
  - Bits [ADDR_W-1:0] are the address, the next DATA_W bits are data, and the final bit is the guard, which must be 0.
  - On each rising edge the shift register shifts right and inserts the sampled mosi at the MSB.
- States:
  - IDLE: mode 01 or 10 → SHIFT; the active mode is latched and the bit counter cleared. Mode 11 → RUN.
  - SHIFT: count sclk rising edges. When the FRAME_LEN-th bit is sampled → COMMIT on the next cycle.
  - COMMIT (1 cycle):
    - Guard 0: wr_en=1 with wr_sel/addr/data registered, valid in the same cycle.
    - Guard 1: frame_err=1 and no write.
    - Bit counter cleared; → SHIFT.
  - RUN: run_out=1 from the first cycle in RUN; done_out = registered halt_in (1-cycle latency). Mode 00 → IDLE with run_out and done_out cleared next cycle.
- Latency: wr_en asserts 1 cycle after the cycle in which the final sclk rising edge is detected in the synced domain.
- done_out in load modes:
  - Set in the cycle after a committed write to address 2^ADDR_W-1.
  - Held until the synced mode changes.
  - Cleared on entry to any other mode.
- Mode change mid-frame (SHIFT with partial bits, different or 00 mode):
  - Partial frame is discarded with no write and no frame_err.
  - New mode is handled as from IDLE in the same cycle.
- Mode change coincident with COMMIT: the commit completes (write issued), then the mode change is processed the next cycle.
- Excess bits: none are possible within one frame; the counter is saturated at FRAME_LEN until COMMIT clears it.
- Mode 11 from a load state: abort any partial frame and go directly to RUN.
- Address wrap: addresses are taken from the frame only; there is no internal address counter, and repeated addresses overwrite.
- wr_en only asserts in COMMIT; it never asserts in IDLE or RUN.
- Reset mid-frame or mid-run: immediate return to the reset state next cycle, with no write strobe.

Test Plan:
- Reset: hold rst 3 cycles with sclk toggling → all outputs 0, no wr_en.
- Single instruction frame: mode=01, send addr=3, data=0xA5, guard 0 → exactly one wr_en with wr_sel=0, wr_addr=3, wr_data=0xA5; done_out stays 0.
- Full data load: mode=10, 16 frames with addr 0..15, data=addr*0x11 → 16 strobes with wr_sel=1 and matching data; done_out=1 after addr 15; mode→00 → done_out=0.
- Guard error: frame with guard=1, addr=5, data=0x3C → frame_err pulse, no wr_en; the next valid frame writes normally.
- Abort: mode=01, 7 bits sent, mode→10, then full frame addr=2, data=0x77 → single write with wr_sel=1, addr 2, data 0x77; partial bits not merged.
- Run handshake: mode=11 → run_out=1; halt_in=1 → done_out=1 one cycle later; mode=00 → run_out=0 and done_out=0.

Source files
------------

// File: rtl/spi_loader_if.sv
// Write-port bundle from the serial loader into the core's instruction/data memories.
interface spi_loader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_sel, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_sel, wr_addr, wr_data);
endinterface

// File: rtl/spi_loader.sv
// Serial program/data loader: deserializes LSB-first frames into memory write strobes
// and hands the core run/halt status in run mode.
module spi_loader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic [1:0]        mode_in,
    input  logic              halt_in,
    spi_loader_if.master      wr,
    output logic              done_out,
    output logic              run_out,
    output logic              frame_err
);
    localparam int unsigned FRAME_LEN = ADDR_W + DATA_W + 1;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    logic [SYNC_STAGES-1:0]      sclk_sync;
    logic [SYNC_STAGES-1:0]      mosi_sync;
    logic [SYNC_STAGES-1:0][1:0] mode_sync;
    logic                        sclk_prev;
    logic                        sclk_s, mosi_s, sclk_rise;
    logic [1:0]                  mode_s;

    logic [1:0]           state, state_d;
    logic [1:0]           ld_mode, ld_mode_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [FRAME_LEN-1:0] sr, sr_d;
    logic                 enter;

    logic              wr_en_d, wr_sel_d, frame_err_d, done_d, run_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign mode_s    = mode_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // Equal-depth synchronizers keep sclk, mosi and mode aligned to each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            mode_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_in};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ld_mode    <= MODE_IDLE;
            cnt        <= '0;
            sr         <= '0;
            wr.wr_en   <= 1'b0;
            wr.wr_sel  <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            frame_err  <= 1'b0;
            done_out   <= 1'b0;
            run_out    <= 1'b0;
        end else begin
            state      <= state_d;
            ld_mode    <= ld_mode_d;
            cnt        <= cnt_d;
            sr         <= sr_d;
            wr.wr_en   <= wr_en_d;
            wr.wr_sel  <= wr_sel_d;
            wr.wr_addr <= wr_addr_d;
            wr.wr_data <= wr_data_d;
            frame_err  <= frame_err_d;
            done_out   <= done_d;
            run_out    <= run_d;
        end
    end

    always_comb begin
        state_d     = state;
        ld_mode_d   = ld_mode;
        cnt_d       = cnt;
        sr_d        = sr;
        enter       = 1'b0;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr.wr_sel;
        wr_addr_d   = wr.wr_addr;
        wr_data_d   = wr.wr_data;
        frame_err_d = 1'b0;
        done_d      = done_out;
        run_d       = 1'b0;

        case (state)
            IDLE: begin
                done_d = 1'b0;
                enter  = 1'b1;
            end
            SHIFT: begin
                if (mode_s != ld_mode) begin
                    // Partial frame is dropped silently; new mode handled as from IDLE.
                    done_d = 1'b0;
                    enter  = 1'b1;
                end else if (sclk_rise) begin
                    sr_d = {mosi_s, sr[FRAME_LEN-1:1]};
                    if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                        // Outputs registered here so they are valid during COMMIT.
                        state_d     = COMMIT;
                        cnt_d       = CNT_W'(FRAME_LEN);
                        frame_err_d = mosi_s;
                        wr_en_d     = ~mosi_s;
                        if (!mosi_s) begin
                            wr_sel_d  = ld_mode[1];
                            wr_addr_d = sr_d[ADDR_W-1:0];
                            wr_data_d = sr_d[ADDR_W +: DATA_W];
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = SHIFT;
                if (wr.wr_en && (&wr.wr_addr))
                    done_d = 1'b1;
            end
            RUN: begin
                if (mode_s != MODE_RUN) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    run_d  = 1'b1;
                    done_d = halt_in;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            if (mode_s == MODE_RUN) begin
                state_d = RUN;
                run_d   = 1'b1;
                done_d  = halt_in;
            end else if (mode_s == MODE_IDLE) begin
                state_d = IDLE;
            end else begin
                state_d   = SHIFT;
                ld_mode_d = mode_s;
                cnt_d     = '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_loader.sv
// Directed bench for spi_loader: reset, instruction/data loads, guard error, abort, run handshake.
module tb_spi_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, halt;
    logic [1:0] mode;
    logic       done_out, run_out, frame_err;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    typedef struct packed {
        logic       sel;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t wq[$];

    spi_loader_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

    spi_loader #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk),
        .mosi_in   (mosi),
        .mode_in   (mode),
        .halt_in   (halt),
        .wr        (ifc),
        .done_out  (done_out),
        .run_out   (run_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Log every strobe seen on the write port, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.wr_en) wq.push_back({ifc.wr_sel, ifc.wr_addr, ifc.wr_data});
            if (frame_err) err_seen = err_seen + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [12:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = f[i];
            sclk = 1'b0;
            tick(4);
            sclk = 1'b1;
            tick(4);
        end
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [7:0] d, input logic g);
        logic [12:0] f;
        f = {g, d, a};
        send_bits(f, 13);
        tick(4);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick(6);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk = ~sclk;
            tick(1);
        end
        sclk = 1'b0;
        rst  = 1'b0;
        tick(1);
        total++; if (ifc.wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%b exp=0", ifc.wr_en); end
        total++; if (done_out !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done_out); end
        total++; if (run_out !== 1'b0)     begin bad++; $display("FAIL reset_run got=%b exp=0", run_out); end
        total++; if (frame_err !== 1'b0)   begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (ifc.wr_addr !== 4'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ifc.wr_addr); end
        total++; if (ifc.wr_data !== 8'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", ifc.wr_data); end
    endtask

    task automatic test_single_instr;
        int base;
        base = wq.size();
        set_mode(2'b01);
        send_frame(4'd3, 8'hA5, 1'b0);
        total++; if (wq.size() - base !== 1) begin bad++; $display("FAIL instr_count got=%0d exp=1", wq.size() - base); end
        if (wq.size() > base) begin
            total++; if (wq[base] !== {1'b0, 4'd3, 8'hA5}) begin bad++; $display("FAIL instr_write got=%h exp=%h", wq[base], {1'b0, 4'd3, 8'hA5}); end
        end
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL instr_done got=%b exp=0", done_out); end
        set_mode(2'b00);
    endtask

    task automatic test_full_data;
        int base;
        logic [7:0] d;
        base = wq.size();
        set_mode(2'b10);
        for (int a = 0; a < 16; a++) begin
            d = 8'(a * 17);
            send_frame(4'(a), d, 1'b0);
            if (a == 14) begin
                total++; if (done_out !== 1'b0) begin bad++; $display("FAIL data_done_early got=%b exp=0", done_out); end
            end
        end
        total++; if (wq.size() - base !== 16) begin bad++; $display("FAIL data_count got=%0d exp=16", wq.size() - base); end
        for (int a = 0; a < 16; a++) begin
            if (base + a < wq.size()) begin
                d = 8'(a * 17);
                total++;
                if (wq[base + a] !== {1'b1, 4'(a), d}) begin
                    bad++; $display("FAIL data_write%0d got=%h exp=%h", a, wq[base + a], {1'b1, 4'(a), d});
                end
            end
        end
        total++; if (done_out !== 1'b1) begin bad++; $display("FAIL data_done got=%b exp=1", done_out); end
        set_mode(2'b00);
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL data_done_clear got=%b exp=0", done_out); end
    endtask

    task automatic test_guard_err;
        int base, ebase;
        set_mode(2'b01);
        base  = wq.size();
        ebase = err_seen;
        send_frame(4'd5, 8'h3C, 1'b1);
        total++; if (err_seen - ebase !== 1) begin bad++; $display("FAIL guard_err_pulses got=%0d exp=1", err_seen - ebase); end
        total++; if (wq.size() - base !== 0) begin bad++; $display("FAIL guard_no_write got=%0d exp=0", wq.size() - base); end
        send_frame(4'd6, 8'h42, 1'b0);
        total++; if (wq.size() - base !== 1) begin bad++; $display("FAIL guard_next_count got=%0d exp=1", wq.size() - base); end
        if (wq.size() > base) begin
            total++; if (wq[base] !== {1'b0, 4'd6, 8'h42}) begin bad++; $display("FAIL guard_next_write got=%h exp=%h", wq[base], {1'b0, 4'd6, 8'h42}); end
        end
        set_mode(2'b00);
    endtask

    task automatic test_abort;
        int base, ebase;
        base  = wq.size();
        ebase = err_seen;
        set_mode(2'b01);
        send_bits(13'h1FFF, 7);
        set_mode(2'b10);
        send_frame(4'd2, 8'h77, 1'b0);
        total++; if (wq.size() - base !== 1) begin bad++; $display("FAIL abort_count got=%0d exp=1", wq.size() - base); end
        if (wq.size() > base) begin
            total++; if (wq[base] !== {1'b1, 4'd2, 8'h77}) begin bad++; $display("FAIL abort_write got=%h exp=%h", wq[base], {1'b1, 4'd2, 8'h77}); end
        end
        total++; if (err_seen - ebase !== 0) begin bad++; $display("FAIL abort_err got=%0d exp=0", err_seen - ebase); end
        set_mode(2'b00);
    endtask

    task automatic test_run;
        int base;
        base = wq.size();
        halt = 1'b0;
        set_mode(2'b11);
        total++; if (run_out !== 1'b1)  begin bad++; $display("FAIL run_on got=%b exp=1", run_out); end
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL run_done_low got=%b exp=0", done_out); end
        halt = 1'b1;
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL run_halt_latency got=%b exp=0", done_out); end
        tick(1);
        total++; if (done_out !== 1'b1) begin bad++; $display("FAIL run_halt_done got=%b exp=1", done_out); end
        send_frame(4'd1, 8'h11, 1'b0);
        total++; if (wq.size() - base !== 0) begin bad++; $display("FAIL run_no_write got=%0d exp=0", wq.size() - base); end
        set_mode(2'b00);
        total++; if (run_out !== 1'b0)  begin bad++; $display("FAIL run_off got=%b exp=0", run_out); end
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL run_done_off got=%b exp=0", done_out); end
        halt = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        mode = 2'b00;
        halt = 1'b0;
        test_reset();
        test_single_instr();
        test_full_data();
        test_guard_err();
        test_abort();
        test_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
